instruction_buffer: RTL and testbench
=====================================

# instruction_buffer

Two-lane instruction queue between the instruction fetch stage and decode. Accepts up to two fetched instructions per cycle with their addresses, stores them in program order in a circular buffer, and presents up to two oldest entries per cycle to decode. Provides backpressure to fetch and a single-cycle flush on jump/redirect.

## Interface

- `ADDR_WIDTH`, 32, instruction address width.
- `DATA_WIDTH`, 32, instruction word width.
- `DEPTH`, 8, entry count; power of two, ≥ 4.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  drop all entries (driven by isJump).
- `instruction_addr_0`  in  ADDR_WIDTH  fetch lane 0 address (older).
- `instruction_addr_1`  in  ADDR_WIDTH  fetch lane 1 address.
- `instruction_0`  in  DATA_WIDTH  fetch lane 0 instruction.
- `instruction_1`  in  DATA_WIDTH  fetch lane 1 instruction.
- `valid`  in  2  per-lane fetch valid.
- `in_ready`  out  1  buffer can take two entries this cycle.
- `out_addr_0`, `out_addr_1`  out  ADDR_WIDTH  head and head+1 addresses.
- `out_instr_0`, `out_instr_1`  out  DATA_WIDTH  head and head+1 instructions.
- `out_valid`  out  2  decode-side valid.
- `out_ready`  in  1  decode accepts all presented valid entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage: DEPTH entries of {addr, instr}, head/tail pointers wrapping mod DEPTH, registered `count`.
- Enqueue fires when `in_ready` and `valid != 0` and not `flush`. Lanes are compacted in order: lane 0 first if `valid[0]`, then lane 1 if `valid[1]`. `valid=2'b10` writes lane 1 into one slot. Tail advances by popcount(`valid`).
- `in_ready` = (DEPTH − count) ≥ 2, computed from registered count only; no combinational path from `out_ready` or `valid`.
- Dequeue: `out_valid` = 2'b11 if count ≥ 2, 2'b01 if count == 1, 2'b00 if empty. Outputs read head and head+1 (wrapped). When `out_ready` and `out_valid != 0` and not `flush`, head advances by popcount(`out_valid`).
- Simultaneous enqueue and dequeue: count_next = count + enq_n − deq_n; both legal in the same cycle, including at wrap-around.
- Flush: highest priority. Head, tail, count cleared to 0 on the next edge; same-cycle enqueue and dequeue discarded.
- Entry data is not cleared by reset or flush; only pointers/count.
- Input with `valid != 0` while `in_ready`=0 is dropped; fetch must hold.

## Timing

- Reset (rst=0): count=0, head=tail=0, `in_ready`=1, `out_valid`=2'b00; output data buses undefined-but-stable (drive entry 0 contents).
- Enqueue-to-output latency: 1 cycle (no bypass); entry written at edge N is visible on `out_*` after edge N.
- Flush at edge N: `out_valid`=0 and `in_ready`=1 after edge N.
- Reset deasserted mid-operation: buffer restarts empty; reset asserting asynchronously forces outputs to reset values immediately.

## Configuration

- `IBUF_PERF_EN`: when defined, adds output `stall_cycles` (32 bits) counting cycles with `valid != 0` and `in_ready`=0, plus `flush_count` (16 bits) counting flush cycles; both wrap, cleared by reset only. When undefined, ports and counters absent; behaviour otherwise identical.

## Test plan

- Reset then enqueue valid=11 with addrs 0x0/0x4, instrs 0xAAAA0001/0xAAAA0002, out_ready=0 → next cycle count=2, out_valid=11, out_addr_0=0x0, out_addr_1=0x4.
- Fill: five cycles of valid=11, out_ready=0, DEPTH=8 → count reaches 8; `in_ready`=0 once count ≥ 7; 5th pair dropped; count stays 8.
- Single entry: enqueue valid=10 with instruction_1=0x12345678 → count=1, out_valid=01, out_instr_0=0x12345678; out_ready=1 → count=0.
- Wrap with concurrent traffic: steady valid=11 and out_ready=1 for 20 cycles → count holds 2, addresses emerge in strict order 0x0,0x4,0x8,... across pointer wrap.
- Flush with count=6 while valid=11 and out_ready=1 → next cycle count=0, out_valid=00, in_ready=1; flushed-cycle input not stored.
- Async reset pulse mid-stream with count=4 → out_valid=00 and count=0 immediately, before next clock edge.

Source files
------------

// File: rtl/instruction_buffer.sv
// ---------------------------------------------------------------------------
// instruction_buffer
//   Two-lane, in-order instruction queue between fetch and decode. Up to two
//   fetched {addr, instr} pairs are written per cycle into a circular buffer;
//   the two oldest entries are presented to decode each cycle.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 asynchronous, active-low reset (pointers/count only)
//   flush               drop all entries on the next edge (highest priority)
//   instruction_addr_0/1, instruction_0/1   fetch lanes (lane 0 is older)
//   valid[1:0]          per-lane fetch valid
//   in_ready            room for two entries (from registered count only)
//   out_addr_0/1, out_instr_0/1             head and head+1 entries
//   out_valid[1:0]      11: >=2 entries, 01: one entry, 00: empty
//   out_ready           decode takes every presented valid entry
//   count               current occupancy
//
// Optional feature (macro IBUF_PERF_EN)
//   Adds stall_cycles (cycles with fetch valid while in_ready is low) and
//   flush_count (flush cycles). Both wrap and are cleared only by reset.
// ---------------------------------------------------------------------------
module instruction_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   instruction_addr_0,
    input  logic [ADDR_WIDTH-1:0]   instruction_addr_1,
    input  logic [DATA_WIDTH-1:0]   instruction_0,
    input  logic [DATA_WIDTH-1:0]   instruction_1,
    input  logic [1:0]              valid,
    output logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   out_addr_0,
    output logic [ADDR_WIDTH-1:0]   out_addr_1,
    output logic [DATA_WIDTH-1:0]   out_instr_0,
    output logic [DATA_WIDTH-1:0]   out_instr_1,
    output logic [1:0]              out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [15:0]             flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage: never reset, only the pointers define what is live.
    logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq_fire;
    logic          deq_fire;
    logic [1:0]    enq_n;
    logic [1:0]    deq_n;
    logic [PW-1:0] wr_idx_1;
    logic [PW-1:0] rd_idx_1;

    // Room for two means count <= DEPTH-2.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    assign out_valid = (count_q >= CW'(2)) ? 2'b11 :
                       (count_q == CW'(1)) ? 2'b01 : 2'b00;

    assign enq_fire = in_ready && (valid != 2'b00) && !flush;
    assign deq_fire = out_ready && (out_valid != 2'b00) && !flush;

    assign enq_n = enq_fire ? ((valid == 2'b11) ? 2'd2 : 2'd1) : 2'd0;
    assign deq_n = deq_fire ? ((out_valid == 2'b11) ? 2'd2 : 2'd1) : 2'd0;

    // Lane compaction: lane 1 lands directly at tail when lane 0 is idle.
    assign wr_idx_1 = valid[0] ? (tail_q + PW'(1)) : tail_q;
    assign rd_idx_1 = head_q + PW'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq_n);
            tail_d  = tail_q + PW'(enq_n);
            count_d = count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (valid[0]) begin
                mem_addr[tail_q]  <= instruction_addr_0;
                mem_instr[tail_q] <= instruction_0;
            end
            if (valid[1]) begin
                mem_addr[wr_idx_1]  <= instruction_addr_1;
                mem_instr[wr_idx_1] <= instruction_1;
            end
        end
    end

    assign out_addr_0  = mem_addr[head_q];
    assign out_instr_0 = mem_instr[head_q];
    assign out_addr_1  = mem_addr[rd_idx_1];
    assign out_instr_1 = mem_instr[rd_idx_1];
    assign count       = count_q;

`ifdef IBUF_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if ((valid != 2'b00) && !in_ready) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
module tb_instruction_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [AW-1:0] instruction_addr_0;
    logic [AW-1:0] instruction_addr_1;
    logic [DW-1:0] instruction_0;
    logic [DW-1:0] instruction_1;
    logic [1:0]    valid;
    logic          in_ready;
    logic [AW-1:0] out_addr_0;
    logic [AW-1:0] out_addr_1;
    logic [DW-1:0] out_instr_0;
    logic [DW-1:0] out_instr_1;
    logic [1:0]    out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
`ifdef IBUF_PERF_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   flush_count;
`endif

    instruction_buffer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .instruction_addr_0 (instruction_addr_0),
        .instruction_addr_1 (instruction_addr_1),
        .instruction_0      (instruction_0),
        .instruction_1      (instruction_1),
        .valid              (valid),
        .in_ready           (in_ready),
        .out_addr_0         (out_addr_0),
        .out_addr_1         (out_addr_1),
        .out_instr_0        (out_instr_0),
        .out_instr_1        (out_instr_1),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .count              (count)
`ifdef IBUF_PERF_EN
        ,
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Scoreboard of live entries, oldest first: {addr, instr}.
    logic [63:0] sb[$];
    logic [AW-1:0] next_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard state.
    task automatic check_state(input string tag);
        logic [1:0] exp_ov;
        int n;
        n = sb.size();
        exp_ov = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        $display("step %s: count=%0d out_valid=%b in_ready=%b addr0=0x%0h addr1=0x%0h",
                 tag, count, out_valid, in_ready, out_addr_0, out_addr_1);
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - n) >= 2));
        if (n >= 1) begin
            chk({tag, ".addr0"}, 64'(out_addr_0), 64'(sb[0][63:32]));
            chk({tag, ".instr0"}, 64'(out_instr_0), 64'(sb[0][31:0]));
        end
        if (n >= 2) begin
            chk({tag, ".addr1"}, 64'(out_addr_1), 64'(sb[1][63:32]));
            chk({tag, ".instr1"}, 64'(out_instr_1), 64'(sb[1][31:0]));
        end
    endtask

    // Apply the model for the currently driven inputs, then advance one edge.
    task automatic cycle();
        bit rdy;
        int n;
        rdy = (DEPTH - sb.size()) >= 2;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_ready) begin
                n = (sb.size() >= 2) ? 2 : sb.size();
                repeat (n) void'(sb.pop_front());
            end
            if (rdy) begin
                if (valid[0]) sb.push_back({instruction_addr_0, instruction_0});
                if (valid[1]) sb.push_back({instruction_addr_1, instruction_1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair();
        valid              = 2'b11;
        instruction_addr_0 = next_addr;
        instruction_addr_1 = next_addr + 32'd4;
        instruction_0      = {16'hC0DE, next_addr[15:0]};
        instruction_1      = {16'hC0DE, next_addr[15:0] + 16'd4};
        next_addr          = next_addr + 32'd8;
    endtask

    task automatic drive_idle();
        valid = 2'b00;
    endtask

    initial begin
        rst                = 1'b0;
        flush              = 1'b0;
        valid              = 2'b00;
        out_ready          = 1'b0;
        instruction_addr_0 = '0;
        instruction_addr_1 = '0;
        instruction_0      = '0;
        instruction_1      = '0;
        next_addr          = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // First pair with explicit values.
        valid              = 2'b11;
        instruction_addr_0 = 32'h0;
        instruction_addr_1 = 32'h4;
        instruction_0      = 32'hAAAA0001;
        instruction_1      = 32'hAAAA0002;
        next_addr          = 32'h8;
        cycle();
        check_state("first_pair");

        // Fill to DEPTH; the last pair is refused.
        for (int i = 0; i < 4; i++) begin
            drive_pair();
            cycle();
            check_state($sformatf("fill%0d", i));
        end

        // Drain.
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_state($sformatf("drain%0d", i));
        end

        // Single entry on lane 1 only.
        out_ready          = 1'b0;
        valid              = 2'b10;
        instruction_addr_1 = 32'h100;
        instruction_1      = 32'h12345678;
        cycle();
        check_state("single");
        drive_idle();
        out_ready = 1'b1;
        cycle();
        check_state("single_deq");

        // Odd occupancy: count 7 must deassert in_ready.
        out_ready          = 1'b0;
        valid              = 2'b01;
        instruction_addr_0 = 32'h200;
        instruction_0      = 32'h0BAD0200;
        cycle();
        check_state("odd1");
        next_addr = 32'h204;
        for (int i = 0; i < 4; i++) begin
            drive_pair();
            cycle();
            check_state($sformatf("odd_fill%0d", i));
        end
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_state($sformatf("odd_drain%0d", i));
        end

        // Steady concurrent traffic across pointer wrap.
        next_addr = 32'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_pair();
            cycle();
            check_state($sformatf("wrap%0d", i));
        end
        drive_idle();
        cycle();
        check_state("wrap_end");

        // Flush with count 6 while both sides are active.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pair();
            cycle();
        end
        check_state("pre_flush");
        drive_pair();
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();
        check_state("flush");
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_idle();
        cycle();
        check_state("post_flush");

        // Asynchronous reset mid-stream with count 4.
        for (int i = 0; i < 2; i++) begin
            drive_pair();
            cycle();
        end
        drive_idle();
        check_state("pre_async");
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        check_state("async_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("async_release");

        // Restart after reset.
        drive_pair();
        cycle();
        check_state("restart");
        drive_idle();
        out_ready = 1'b1;
        cycle();
        check_state("restart_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
